// File: rtl/booth_mult_scheduler.sv
// booth_mult_scheduler
//   Shares one signed WIDTH x WIDTH multiplier core among NUM_REQ requesters.
//   Round-robin grant, one op in flight, result tagged with requester index.
// Ports
//   CLK, RESET          clock, synchronous active-low reset
//   req_valid/req_ready per-requester handshake (req_ready one-hot, combinational)
//   req_a, req_b        packed operands, requester i at [i*WIDTH +: WIDTH]
//   mul_x, mul_y        held operands driven to the core
//   mul_z               core product, valid MUL_LATENCY cycles after X/Y change
//   rsp_valid/rsp_ready response handshake; rsp_id, rsp_product held until accepted
//   busy                high whenever the FSM is not IDLE
module booth_mult_scheduler #(
  parameter int NUM_REQ     = 4,
  parameter int WIDTH       = 32,
  parameter int MUL_LATENCY = 1,
  localparam int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [WIDTH-1:0]         mul_x,
  output logic [WIDTH-1:0]         mul_y,
  input  logic [2*WIDTH-1:0]       mul_z,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [2*WIDTH-1:0]       rsp_product,
  output logic                     busy
);

  localparam int CNT_W = $clog2(MUL_LATENCY + 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t                         state;
  logic [ID_W-1:0]                last_grant;
  logic [CNT_W-1:0]               cnt;
  logic [NUM_REQ-1:0][WIDTH-1:0]  a_arr, b_arr;
  logic [ID_W-1:0]                gnt_id;
  logic                           gnt_any;

  assign a_arr = req_a;
  assign b_arr = req_b;
  assign busy  = (state != IDLE);

  // Walk from farthest to nearest candidate after last_grant so the
  // nearest valid requester is the one left in gnt_id.
  always_comb begin
    gnt_id  = '0;
    gnt_any = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      int idx;
      idx = (int'(last_grant) + k) % NUM_REQ;
      if (req_valid[idx]) begin
        gnt_id  = ID_W'(idx);
        gnt_any = 1'b1;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (RESET && state == IDLE && gnt_any) req_ready[gnt_id] = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state       <= IDLE;
      rsp_valid   <= 1'b0;
      rsp_id      <= '0;
      rsp_product <= '0;
      mul_x       <= '0;
      mul_y       <= '0;
      last_grant  <= ID_W'(NUM_REQ - 1);  // requester 0 wins first
      cnt         <= '0;
    end else begin
      case (state)
        IDLE: if (gnt_any) begin
          mul_x      <= a_arr[gnt_id];
          mul_y      <= b_arr[gnt_id];
          rsp_id     <= gnt_id;
          last_grant <= gnt_id;
          cnt        <= '0;
          state      <= BUSY;
        end
        // MUL_LATENCY+1 cycles: one for the operand registers to reach
        // the core, MUL_LATENCY for the core itself.
        BUSY: if (cnt == CNT_W'(MUL_LATENCY)) begin
          rsp_product <= mul_z;
          rsp_valid   <= 1'b1;
          state       <= RESP;
        end else begin
          cnt <= cnt + 1'b1;
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mult_scheduler.sv
// Bench for booth_mult_scheduler: behavioural core model, scoreboard of
// expected (id, product) pushed at accept and popped at response handshake.
module tb_booth_mult_scheduler;
  localparam int NR = 4, W = 32, ML = 1;

  logic            CLK = 1'b0;
  logic            RESET;
  logic [NR-1:0]   req_valid;
  logic [NR*W-1:0] req_a, req_b;
  logic [NR-1:0]   req_ready;
  logic [W-1:0]    mul_x, mul_y;
  logic [2*W-1:0]  mul_z;
  logic            rsp_valid, rsp_ready;
  logic [1:0]      rsp_id;
  logic [2*W-1:0]  rsp_product;
  logic            busy;

  always #5 CLK = ~CLK;

  booth_mult_scheduler #(.NUM_REQ(NR), .WIDTH(W), .MUL_LATENCY(ML)) dut (
    .CLK(CLK), .RESET(RESET), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .mul_x(mul_x), .mul_y(mul_y), .mul_z(mul_z),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_product(rsp_product), .busy(busy)
  );

  // core model: ML-stage registered signed product
  logic [2*W-1:0] zpipe [ML];
  always @(posedge CLK) begin
    logic signed [2*W-1:0] sx, sy;
    sx = $signed(mul_x);
    sy = $signed(mul_y);
    zpipe[0] <= sx * sy;
    for (int i = 1; i < ML; i++) zpipe[i] <= zpipe[i-1];
  end
  assign mul_z = zpipe[ML-1];

  typedef struct { logic [1:0] id; logic [2*W-1:0] p; } exp_t;
  exp_t exp_q[$];
  int   gnt_q[$];
  int   gnt_cyc[$];
  logic [2*W-1:0] rsp_log[$];

  int vec = 0, errs = 0, cyc = 0, acc_cyc = 0;
  logic rv_prev = 1'b0;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    vec++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge CLK) begin
    cyc++;
    if (RESET && req_ready != '0) begin
      chk("onehot", 64'($countones(req_ready)), 64'd1);
      for (int i = 0; i < NR; i++) if (req_ready[i]) begin
        logic signed [2*W-1:0] pa, pb;
        exp_t e;
        chk("rdy_vld", 64'(req_valid[i]), 64'd1);
        pa = $signed(req_a[i*W +: W]);
        pb = $signed(req_b[i*W +: W]);
        e.id = 2'(i);
        e.p  = pa * pb;
        exp_q.push_back(e);
        gnt_q.push_back(i);
        gnt_cyc.push_back(cyc);
        acc_cyc = cyc;
      end
    end
    if (rsp_valid && !rv_prev) chk("latency", 64'(cyc - acc_cyc), 64'(ML + 2));
    rv_prev = rsp_valid;
    if (rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) chk("spurious_rsp", 64'd1, 64'd0);
      else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rsp_id", 64'(rsp_id), 64'(e.id));
        chk("rsp_prod", rsp_product, e.p);
        rsp_log.push_back(rsp_product);
      end
    end
  end

  task automatic do_reset();
    @(posedge CLK); #1;
    RESET = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b1;
  endtask

  task automatic wait_gnt(int n_gnt, string tag);
    int n = 0;
    while (gnt_q.size() < n_gnt && n < 200) begin @(negedge CLK); n++; end
    chk(tag, 64'(n < 200), 64'd1);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin @(negedge CLK); n++; end
    chk("drain_to", 64'(n < 200), 64'd1);
  endtask

  task automatic op(int i, logic [W-1:0] a, logic [W-1:0] b, logic [2*W-1:0] exp);
    int n;
    @(posedge CLK); #1;
    req_valid[i] = 1'b1;
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    n = 0;
    do begin @(negedge CLK); n++; end while (!req_ready[i] && n < 50);
    chk("acc_to", 64'(n < 50), 64'd1);
    @(posedge CLK); #1;
    req_valid[i] = 1'b0;
    n = 0;
    while (!rsp_valid && n < 50) begin @(negedge CLK); n++; end
    chk("rsp_to", 64'(n < 50), 64'd1);
    chk("op_prod", rsp_product, exp);
    chk("op_id", 64'(rsp_id), 64'(i));
    @(posedge CLK);
  endtask

  initial begin
    RESET = 1'b0; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;

    // reset state, requests ignored while in reset
    req_valid = '1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_id", 64'(rsp_id), 64'd0);
    chk("rst_prod", rsp_product, 64'd0);
    chk("rst_mul_x", 64'(mul_x), 64'd0);
    chk("rst_mul_y", 64'(mul_y), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ready", 64'(req_ready), 64'd0);
    req_valid = '0;
    @(posedge CLK); #1 RESET = 1'b1;

    // single op on requester 0
    op(0, 32'd15, -32'sd31, 64'hFFFF_FFFF_FFFF_FE2F);

    // fairness with all four continuously valid
    do_reset();
    gnt_q.delete(); gnt_cyc.delete(); rsp_log.delete();
    for (int i = 0; i < NR; i++) begin
      req_a[i*W +: W] = -32'sd81;
      req_b[i*W +: W] = 32'(-55 + i);
    end
    req_valid = '1;
    wait_gnt(5, "rr_to");
    @(posedge CLK); #1 req_valid = '0;
    drain();
    if (gnt_q.size() >= 5) begin
      int order [5] = '{0, 1, 2, 3, 0};
      for (int k = 0; k < 5; k++) chk($sformatf("rr_gnt%0d", k), 64'(gnt_q[k]), 64'(order[k]));
      chk("rr_period", 64'(gnt_cyc[1] - gnt_cyc[0]), 64'(ML + 3));
    end
    if (rsp_log.size() > 0) chk("rr_first_prod", rsp_log[0], 64'd4455);

    // backpressure in RESP, a waiting requester must not be accepted
    rsp_ready = 1'b0;
    @(posedge CLK); #1;
    req_valid[1] = 1'b1; req_a[1*W +: W] = 32'd7; req_b[1*W +: W] = 32'd9;
    begin
      int n = 0;
      do begin @(negedge CLK); n++; end while (!req_ready[1] && n < 50);
      @(posedge CLK); #1 req_valid[1] = 1'b0;
      n = 0;
      while (!rsp_valid && n < 50) begin @(negedge CLK); n++; end
      chk("bp_rsp_to", 64'(n < 50), 64'd1);
    end
    @(posedge CLK); #1;
    req_valid[2] = 1'b1; req_a[2*W +: W] = 32'd3; req_b[2*W +: W] = -32'sd4;
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      chk("bp_valid", 64'(rsp_valid), 64'd1);
      chk("bp_id", 64'(rsp_id), 64'd1);
      chk("bp_prod", rsp_product, 64'd63);
      chk("bp_ready", 64'(req_ready), 64'd0);
      chk("bp_busy", 64'(busy), 64'd1);
    end
    @(posedge CLK); #1 rsp_ready = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    chk("bp_idle_busy", 64'(busy), 64'd0);
    chk("bp_idle_valid", 64'(rsp_valid), 64'd0);
    chk("bp_idle_ready", 64'(req_ready), 64'b0100);
    @(posedge CLK); #1 req_valid[2] = 1'b0;
    drain();

    // edge operands
    op(0, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
    op(1, 32'd0, -32'sd300, 64'd0);
    op(3, 32'd122, 32'd1, 64'd122);

    // reset while BUSY discards the op and re-points to requester 0
    @(posedge CLK); #1;
    req_valid[1] = 1'b1; req_a[1*W +: W] = 32'd5; req_b[1*W +: W] = 32'd6;
    begin
      int n = 0;
      do begin @(negedge CLK); n++; end while (!req_ready[1] && n < 50);
      chk("rb_acc_to", 64'(n < 50), 64'd1);
    end
    @(posedge CLK); #1;
    req_valid = '0;
    RESET = 1'b0;
    exp_q.delete();
    @(negedge CLK);
    chk("rb_busy_pre", 64'(busy), 64'd1);
    @(negedge CLK);
    chk("rb_busy", 64'(busy), 64'd0);
    chk("rb_valid", 64'(rsp_valid), 64'd0);
    @(posedge CLK); #1 RESET = 1'b1;
    repeat (ML + 4) @(negedge CLK);
    chk("rb_no_rsp", 64'(rsp_valid), 64'd0);
    gnt_q.delete();
    @(posedge CLK); #1 req_valid = '1;
    wait_gnt(1, "rb_gnt_to");
    @(posedge CLK); #1 req_valid = '0;
    if (gnt_q.size() > 0) chk("rb_gnt0", 64'(gnt_q[0]), 64'd0);
    drain();

    // pointer wrap: 2 alone, then 1 and 3 -> 2,3,1
    gnt_q.delete(); gnt_cyc.delete();
    @(posedge CLK); #1 req_valid = 4'b0100;
    wait_gnt(1, "wr_to1");
    @(posedge CLK); #1 req_valid = 4'b1010;
    wait_gnt(3, "wr_to3");
    @(posedge CLK); #1 req_valid = '0;
    drain();
    if (gnt_q.size() >= 3) begin
      chk("wr_gnt0", 64'(gnt_q[0]), 64'd2);
      chk("wr_gnt1", 64'(gnt_q[1]), 64'd3);
      chk("wr_gnt2", 64'(gnt_q[2]), 64'd1);
      chk("wr_per1", 64'(gnt_cyc[1] - gnt_cyc[0]), 64'(ML + 3));
      chk("wr_per2", 64'(gnt_cyc[2] - gnt_cyc[1]), 64'(ML + 3));
    end

    repeat (4) @(posedge CLK);
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
